// File: rtl/rom_burst_arbiter.sv
// rom_burst_arbiter
// Round-robin arbiter and burst sequencer that shares one synchronous ROM
// between two read requesters. A granted channel receives len+1 consecutive
// ROM words, with the address wrapping modulo 2^ADDR_W.
//
// Ports
//   clk, rst_n           clock, asynchronous active-low reset
//   req_0/1              level-sensitive burst request per channel
//   addr_0/1, len_0/1    burst start address and length-minus-one (sampled at grant)
//   gnt_0/1              one-cycle grant pulse
//   valid_0/1            rd_data carries a beat for that channel
//   done_0/1             one-cycle pulse coincident with the last beat
//   rd_data              pass-through of rom_data
//   busy                 sequencer is not idle
//   rom_addr             registered ROM address
//   rom_data             ROM output, valid one edge after its address
module rom_burst_arbiter #(
  parameter int unsigned ADDR_W = 3,
  parameter int unsigned DATA_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_0,
  input  logic              req_1,
  input  logic [ADDR_W-1:0] addr_0,
  input  logic [ADDR_W-1:0] addr_1,
  input  logic [ADDR_W-1:0] len_0,
  input  logic [ADDR_W-1:0] len_1,
  output logic              gnt_0,
  output logic              gnt_1,
  output logic              valid_0,
  output logic              valid_1,
  output logic              done_0,
  output logic              done_1,
  output logic [DATA_W-1:0] rd_data,
  output logic              busy,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data
);

  typedef enum logic [1:0] {StIdle, StBurst, StDrain} state_e;

  state_e            state_q, state_d;
  logic              owner_q, owner_d;
  logic              last_q, last_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [1:0]        gnt_q, gnt_d;
  logic [1:0]        valid_q, valid_d;
  logic [1:0]        done_q, done_d;
  logic              pick;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      owner_q <= 1'b0;
      last_q  <= 1'b1;  // channel 0 wins the first tie
      cnt_q   <= '0;
      addr_q  <= '0;
      gnt_q   <= '0;
      valid_q <= '0;
      done_q  <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      gnt_q   <= gnt_d;
      valid_q <= valid_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    gnt_d   = '0;
    valid_d = '0;
    done_d  = '0;
    pick    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (req_0 || req_1) begin
          // On a tie the channel not granted last time wins.
          pick         = (req_0 && req_1) ? ~last_q : req_1;
          gnt_d[pick]  = 1'b1;
          owner_d      = pick;
          last_d       = pick;
          addr_d       = pick ? addr_1 : addr_0;
          cnt_d        = pick ? len_1 : len_0;
          state_d      = StBurst;
        end
      end
      StBurst: begin
        // Every BURST cycle yields a beat on the next edge, as the ROM
        // returns the word one edge after its address.
        valid_d[owner_q] = 1'b1;
        if (cnt_q != '0) begin
          addr_d = addr_q + ADDR_W'(1);
          cnt_d  = cnt_q - ADDR_W'(1);
        end else begin
          done_d[owner_q] = 1'b1;
          state_d         = StDrain;
        end
      end
      StDrain: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  assign gnt_0    = gnt_q[0];
  assign gnt_1    = gnt_q[1];
  assign valid_0  = valid_q[0];
  assign valid_1  = valid_q[1];
  assign done_0   = done_q[0];
  assign done_1   = done_q[1];
  assign rd_data  = rom_data;
  assign busy     = (state_q != StIdle);
  assign rom_addr = addr_q;

endmodule

// File: tb/tb_rom_burst_arbiter.sv
module tb_rom_burst_arbiter;
  localparam int AW = 3;
  localparam int DW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req_0, req_1;
  logic [AW-1:0] addr_0, addr_1, len_0, len_1;
  logic          gnt_0, gnt_1, valid_0, valid_1, done_0, done_1, busy;
  logic [DW-1:0] rd_data, rom_data;
  logic [AW-1:0] rom_addr;

  rom_burst_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_0(req_0), .req_1(req_1),
    .addr_0(addr_0), .addr_1(addr_1), .len_0(len_0), .len_1(len_1),
    .gnt_0(gnt_0), .gnt_1(gnt_1), .valid_0(valid_0), .valid_1(valid_1),
    .done_0(done_0), .done_1(done_1), .rd_data(rd_data), .busy(busy),
    .rom_addr(rom_addr), .rom_data(rom_data)
  );

  always #5 clk = ~clk;

  // ROM contents 1,2,4,8,1,2,4,8
  function automatic logic [DW-1:0] rom_val(input int a);
    return DW'(1 << (a % 4));
  endfunction

  // Synchronous ROM stand-in, no reset.
  always @(posedge clk) rom_data <= rom_val(int'(rom_addr));

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;
  bit last_m = 1'b1;     // last granted channel
  int addr_m = 0;        // expected idle rom_addr
  int done_cyc = 0;
  bit gap_chk = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_gnt"}, {gnt_0, gnt_1}, 0);
    check({tag, "_valid"}, {valid_0, valid_1}, 0);
    check({tag, "_done"}, {done_0, done_1}, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_rom_addr"}, rom_addr, 0);
  endtask

  task automatic idle_cycles(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      check("idle_busy", busy, 0);
      check("idle_rom_addr", rom_addr, addr_m);
      check("idle_valid", {valid_0, valid_1}, 0);
    end
  endtask

  // Request a burst; the model picks the winner and predicts every beat.
  // abort_beat >= 0 applies reset right after that (0-based) beat.
  task automatic do_burst(input bit r0, input bit r1, input int a0, input int a1,
                          input int l0, input int l1, input bit hold, input int abort_beat);
    int ch, a, l, nxt;
    bit got;
    ch = (r0 && r1) ? (last_m ? 0 : 1) : (r0 ? 0 : 1);
    a  = ch ? a1 : a0;
    l  = ch ? l1 : l0;
    req_0 = r0; req_1 = r1;
    addr_0 = AW'(a0); addr_1 = AW'(a1);
    len_0 = AW'(l0); len_1 = AW'(l1);
    got = 1'b0;
    for (int w = 0; w < 12 && !got; w++) begin
      @(negedge clk);
      if (gnt_0 || gnt_1) got = 1'b1;
    end
    check("grant_seen", got, 1);
    if (!got) begin
      req_0 = 1'b0; req_1 = 1'b0;
      return;
    end
    last_m = ch[0];
    check("gnt_0", gnt_0, ch == 0);
    check("gnt_1", gnt_1, ch == 1);
    check("grant_rom_addr", rom_addr, a);
    check("grant_busy", busy, 1);
    if (gap_chk) check("grant_gap", cyc - done_cyc, 2);
    if (!hold) begin
      req_0 = 1'b0; req_1 = 1'b0;
      // addr/len after the grant must not matter
      addr_0 = AW'($urandom); addr_1 = AW'($urandom);
      len_0 = AW'($urandom); len_1 = AW'($urandom);
    end
    for (int i = 0; i <= l; i++) begin
      @(negedge clk);
      nxt = (i + 1 < l) ? i + 1 : l;
      check("valid_own", ch ? valid_1 : valid_0, 1);
      check("valid_other", ch ? valid_0 : valid_1, 0);
      check("rd_data", rd_data, rom_val(a + i));
      check("done_own", ch ? done_1 : done_0, i == l);
      check("done_other", ch ? done_0 : done_1, 0);
      check("gnt_pulse", {gnt_0, gnt_1}, 0);
      check("beat_busy", busy, 1);
      check("beat_rom_addr", rom_addr, (a + nxt) % 8);
      if (i == abort_beat) begin
        req_0 = 1'b0; req_1 = 1'b0;
        rst_n = 1'b0;
        #1;
        check_all_zero("abort");
        last_m = 1'b1; addr_m = 0; gap_chk = 1'b0;
        @(negedge clk);
        check_all_zero("abort_hold");
        rst_n = 1'b1;
        return;
      end
    end
    done_cyc = cyc;
    @(negedge clk);
    check("post_busy", busy, 0);
    check("post_valid", {valid_0, valid_1}, 0);
    check("post_done", {done_0, done_1}, 0);
    addr_m  = (a + l) % 8;
    gap_chk = hold;
  endtask

  initial begin
    int r;
    rst_n = 1'b0;
    req_0 = 1'b0; req_1 = 1'b0;
    addr_0 = '0; addr_1 = '0; len_0 = '0; len_1 = '0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;
    idle_cycles(3);

    do_burst(1'b1, 1'b0, 2, 0, 3, 0, 1'b0, -1);   // 4,8,1,2
    do_burst(1'b0, 1'b1, 0, 6, 0, 3, 1'b0, -1);   // wrap 6,7,0,1
    do_burst(1'b1, 1'b0, 5, 0, 7, 0, 1'b0, -1);   // whole ROM
    idle_cycles(2);

    // Round-robin from reset with both requests held
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    last_m = 1'b1; addr_m = 0; gap_chk = 1'b0;
    idle_cycles(1);
    do_burst(1'b1, 1'b1, 1, 4, 1, 2, 1'b1, -1);
    do_burst(1'b1, 1'b1, 1, 4, 1, 2, 1'b1, -1);
    do_burst(1'b1, 1'b1, 1, 4, 1, 2, 1'b0, -1);
    idle_cycles(2);

    // Reset mid-burst, then a single-beat burst
    do_burst(1'b0, 1'b1, 0, 0, 0, 7, 1'b0, 2);
    idle_cycles(2);
    do_burst(1'b1, 1'b0, 1, 0, 0, 0, 1'b0, -1);
    idle_cycles(1);

    // Random traffic
    for (int n = 0; n < 25; n++) begin
      r = int'($urandom_range(1, 3));
      do_burst(r[0], r[1], int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
               int'($urandom_range(0, 7)), int'($urandom_range(0, 7)), 1'b0, -1);
      idle_cycles(int'($urandom_range(0, 2)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, observed timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
